// File: rtl/idu_operand_forward_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// idu_operand_forward_if : IDU operand-forward bus (decode side, EXU side)
// Rev 1.0
// ---------------------------------------------------------------------------
interface idu_operand_forward_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       rs1_choice;
  logic [2:0]       rs2_choice;
  logic [XLEN-1:0]  rf_rdata1;
  logic [XLEN-1:0]  rf_rdata2;
  logic [XLEN-1:0]  exu_result;
  logic [XLEN-1:0]  wbu_wdata;
  logic [XLEN-1:0]  mem_alu_result;
  logic [XLEN-1:0]  mem_load_data;
  logic             mem_load_valid;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  op1;
  logic [XLEN-1:0]  op2;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output flush, in_valid, rs1_choice, rs2_choice, rf_rdata1, rf_rdata2,
           exu_result, wbu_wdata, mem_alu_result, mem_load_data,
           mem_load_valid, out_ready,
    input  in_ready, out_valid, op1, op2, stall_cnt
  );

  modport slave (
    input  flush, in_valid, rs1_choice, rs2_choice, rf_rdata1, rf_rdata2,
           exu_result, wbu_wdata, mem_alu_result, mem_load_data,
           mem_load_valid, out_ready,
    output in_ready, out_valid, op1, op2, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/idu_operand_forward.sv
`default_nettype none
// ---------------------------------------------------------------------------
// idu_operand_forward : selects IDU operands from RF/forward paths, stalls on
// load-use, presents registered operands to EXU. Rev 1.0
// ---------------------------------------------------------------------------
module idu_operand_forward #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  wire                 clk,
  input  wire                 rst,
  idu_operand_forward_if.slave bus
);

  typedef enum logic [0:0] {
    S_IDLE      = 1'b0,
    S_WAIT_LOAD = 1'b1
  } state_t;

  localparam logic [2:0] c_SEL_LOAD = 3'b011;

  state_t           r_state, w_state_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic [XLEN-1:0]  r_op1, w_op1_nxt;
  logic [XLEN-1:0]  r_op2, w_op2_nxt;
  logic             r_pend1, w_pend1_nxt;
  logic             r_pend2, w_pend2_nxt;
  logic [CNT_W-1:0] r_stall_cnt, w_stall_cnt_nxt;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_ld1;
  logic             w_ld2;
  logic [XLEN-1:0]  w_fwd1;
  logic [XLEN-1:0]  w_fwd2;

  function automatic logic [XLEN-1:0] f_pick(
    input logic [2:0]      sel,
    input logic [XLEN-1:0] rf,
    input logic [XLEN-1:0] exu,
    input logic [XLEN-1:0] wbu,
    input logic [XLEN-1:0] ld,
    input logic [XLEN-1:0] alu
  );
    logic [XLEN-1:0] v;
    case (sel)
      3'b001:  v = exu;
      3'b010:  v = wbu;
      3'b011:  v = ld;
      3'b100:  v = alu;
      default: v = rf;
    endcase
    return v;
  endfunction

  assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_ld1      = (bus.rs1_choice == c_SEL_LOAD);
  assign w_ld2      = (bus.rs2_choice == c_SEL_LOAD);

  assign w_fwd1 = f_pick(bus.rs1_choice, bus.rf_rdata1, bus.exu_result,
                         bus.wbu_wdata, bus.mem_load_data, bus.mem_alu_result);
  assign w_fwd2 = f_pick(bus.rs2_choice, bus.rf_rdata2, bus.exu_result,
                         bus.wbu_wdata, bus.mem_load_data, bus.mem_alu_result);

  always_comb begin
    w_state_nxt     = r_state;
    w_out_valid_nxt = r_out_valid;
    w_op1_nxt       = r_op1;
    w_op2_nxt       = r_op2;
    w_pend1_nxt     = r_pend1;
    w_pend2_nxt     = r_pend2;
    w_stall_cnt_nxt = r_stall_cnt;

    if (bus.flush) begin
      w_state_nxt     = S_IDLE;
      w_out_valid_nxt = 1'b0;
      w_pend1_nxt     = 1'b0;
      w_pend2_nxt     = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_op1_nxt = w_fwd1;
            w_op2_nxt = w_fwd2;
            if ((w_ld1 || w_ld2) && !bus.mem_load_valid) begin
              // Load-dependent operands are filled in when the load returns.
              w_pend1_nxt     = w_ld1;
              w_pend2_nxt     = w_ld2;
              w_out_valid_nxt = 1'b0;
              w_state_nxt     = S_WAIT_LOAD;
            end else begin
              w_out_valid_nxt = 1'b1;
            end
          end else if (bus.out_ready) begin
            w_out_valid_nxt = 1'b0;
          end
        end
        S_WAIT_LOAD: begin
          if (r_stall_cnt != {CNT_W{1'b1}}) begin
            w_stall_cnt_nxt = r_stall_cnt + CNT_W'(1);
          end
          if (bus.mem_load_valid) begin
            if (r_pend1) w_op1_nxt = bus.mem_load_data;
            if (r_pend2) w_op2_nxt = bus.mem_load_data;
            w_pend1_nxt     = 1'b0;
            w_pend2_nxt     = 1'b0;
            w_out_valid_nxt = 1'b1;
            w_state_nxt     = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_pend1     <= 1'b0;
      r_pend2     <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_op1       <= w_op1_nxt;
      r_op2       <= w_op2_nxt;
      r_pend1     <= w_pend1_nxt;
      r_pend2     <= w_pend2_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.op1       = r_op1;
  assign bus.op2       = r_op2;
  assign bus.stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_idu_operand_forward.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_idu_operand_forward : directed scenarios plus randomized run against a
// transaction-level reference model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_idu_operand_forward;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  idu_operand_forward_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  idu_operand_forward #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: "busy waiting for a load" plus what EXU should see.
  logic             m_busy, m_need1, m_need2, m_ov;
  logic [XLEN-1:0]  m_op1, m_op2;
  logic [CNT_W-1:0] m_stall;

  function automatic logic [XLEN-1:0] source_of(input logic [2:0] c, input logic [XLEN-1:0] rf);
    if (c == 3'd1) return bus.exu_result;
    if (c == 3'd2) return bus.wbu_wdata;
    if (c == 3'd3) return bus.mem_load_data;
    if (c == 3'd4) return bus.mem_alu_result;
    return rf;
  endfunction

  function automatic logic model_ready();
    return !m_busy && (!m_ov || bus.out_ready);
  endfunction

  task automatic tick();
    logic take;
    take = bus.in_valid && model_ready();
    if (rst) begin
      m_busy = 0; m_need1 = 0; m_need2 = 0; m_ov = 0; m_op1 = '0; m_op2 = '0; m_stall = '0;
    end else if (bus.flush) begin
      m_busy = 0; m_need1 = 0; m_need2 = 0; m_ov = 0;
    end else if (m_busy) begin
      if (m_stall != '1) m_stall = m_stall + 1;
      if (bus.mem_load_valid) begin
        if (m_need1) m_op1 = bus.mem_load_data;
        if (m_need2) m_op2 = bus.mem_load_data;
        m_need1 = 0; m_need2 = 0; m_busy = 0; m_ov = 1;
      end
    end else if (take) begin
      if (bus.rs1_choice != 3'd3) m_op1 = source_of(bus.rs1_choice, bus.rf_rdata1);
      if (bus.rs2_choice != 3'd3) m_op2 = source_of(bus.rs2_choice, bus.rf_rdata2);
      if ((bus.rs1_choice == 3'd3 || bus.rs2_choice == 3'd3) && !bus.mem_load_valid) begin
        m_need1 = (bus.rs1_choice == 3'd3);
        m_need2 = (bus.rs2_choice == 3'd3);
        m_busy  = 1; m_ov = 0;
      end else begin
        if (bus.rs1_choice == 3'd3) m_op1 = bus.mem_load_data;
        if (bus.rs2_choice == 3'd3) m_op2 = bus.mem_load_data;
        m_ov = 1;
      end
    end else if (bus.out_ready) begin
      m_ov = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush = 0; bus.in_valid = 0; bus.rs1_choice = 0; bus.rs2_choice = 0;
    bus.rf_rdata1 = 0; bus.rf_rdata2 = 0; bus.exu_result = 0; bus.wbu_wdata = 0;
    bus.mem_alu_result = 0; bus.mem_load_data = 0; bus.mem_load_valid = 0; bus.out_ready = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; tick(); tick(); rst = 0; #1;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
    n_vec++; if (bus.op1 !== '0 || bus.op2 !== '0) begin n_miss++; $display("FAIL reset_ops got %h/%h want 0/0", bus.op1, bus.op2); end
    n_vec++; if (bus.stall_cnt !== '0) begin n_miss++; $display("FAIL reset_stall got %0d want 0", bus.stall_cnt); end
    n_vec++; if (bus.in_ready !== 1'b1) begin n_miss++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_no_hazard();
    bus.rs1_choice = 3'b000; bus.rs2_choice = 3'b001;
    bus.rf_rdata1 = 32'h11; bus.exu_result = 32'h22; bus.in_valid = 1; bus.out_ready = 1; #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_miss++; $display("FAIL nohaz_in_ready got %0b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 0; #1;
    n_vec++; if (bus.out_valid !== 1'b1 || bus.op1 !== 32'h11 || bus.op2 !== 32'h22) begin
      n_miss++; $display("FAIL nohaz_out got v=%0b %h/%h want 1 11/22", bus.out_valid, bus.op1, bus.op2); end
    n_vec++; if (bus.in_ready !== 1'b1) begin n_miss++; $display("FAIL nohaz_in_ready2 got %0b want 1", bus.in_ready); end
    tick();
  endtask

  task automatic test_load_use();
    bus.rs1_choice = 3'b010; bus.wbu_wdata = 32'hA; bus.rs2_choice = 3'b011;
    bus.mem_load_valid = 0; bus.in_valid = 1; #1;
    tick();
    bus.in_valid = 0; bus.wbu_wdata = 32'hDEAD;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin bus.mem_load_valid = 1; bus.mem_load_data = 32'hBEEF; end
      #1;
      n_vec++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
        n_miss++; $display("FAIL loaduse_stall[%0d] got rdy=%0b v=%0b want 0/0", i, bus.in_ready, bus.out_valid); end
      tick();
    end
    bus.mem_load_valid = 0;
    n_vec++; if (bus.out_valid !== 1'b1 || bus.op1 !== 32'hA || bus.op2 !== 32'hBEEF) begin
      n_miss++; $display("FAIL loaduse_out got v=%0b %h/%h want 1 A/BEEF", bus.out_valid, bus.op1, bus.op2); end
    n_vec++; if (bus.stall_cnt !== 32'd3) begin n_miss++; $display("FAIL loaduse_stall_cnt got %0d want 3", bus.stall_cnt); end
    tick();
  endtask

  task automatic test_both_load_same_cycle();
    bus.rs1_choice = 3'b011; bus.rs2_choice = 3'b011; bus.mem_load_valid = 1;
    bus.mem_load_data = 32'h5; bus.in_valid = 1; #1;
    tick();
    bus.in_valid = 0; bus.mem_load_valid = 0; #1;
    n_vec++; if (bus.out_valid !== 1'b1 || bus.op1 !== 32'h5 || bus.op2 !== 32'h5) begin
      n_miss++; $display("FAIL bothload_out got v=%0b %h/%h want 1 5/5", bus.out_valid, bus.op1, bus.op2); end
    n_vec++; if (bus.stall_cnt !== 32'd3) begin n_miss++; $display("FAIL bothload_stall got %0d want 3", bus.stall_cnt); end
    tick();
  endtask

  task automatic test_backpressure();
    bus.rs1_choice = 0; bus.rs2_choice = 0; bus.rf_rdata1 = 32'h100; bus.rf_rdata2 = 32'h200;
    bus.in_valid = 1; bus.out_ready = 0; #1;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.rf_rdata1 = $urandom; bus.rf_rdata2 = $urandom; bus.rs1_choice = 3'($urandom_range(0, 2)); #1;
      n_vec++; if (bus.in_ready !== 1'b0) begin n_miss++; $display("FAIL bp_in_ready[%0d] got %0b want 0", i, bus.in_ready); end
      n_vec++; if (bus.out_valid !== 1'b1 || bus.op1 !== 32'h100 || bus.op2 !== 32'h200) begin
        n_miss++; $display("FAIL bp_hold[%0d] got v=%0b %h/%h want 1 100/200", i, bus.out_valid, bus.op1, bus.op2); end
      tick();
    end
    bus.out_ready = 1; bus.rs1_choice = 0; bus.rf_rdata1 = 32'h300; bus.rf_rdata2 = 32'h400; #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_miss++; $display("FAIL bp_release_ready got %0b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 0; #1;
    n_vec++; if (bus.out_valid !== 1'b1 || bus.op1 !== 32'h300 || bus.op2 !== 32'h400) begin
      n_miss++; $display("FAIL bp_next got v=%0b %h/%h want 1 300/400", bus.out_valid, bus.op1, bus.op2); end
    tick();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_miss++; $display("FAIL bp_drain got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_flush_wait();
    bus.rs1_choice = 3'b011; bus.rs2_choice = 0; bus.mem_load_valid = 0; bus.in_valid = 1; #1;
    tick();
    bus.in_valid = 0;
    tick();
    bus.flush = 1; bus.in_valid = 1; #1;
    tick();
    bus.flush = 0; bus.in_valid = 0; bus.mem_load_valid = 1; bus.mem_load_data = 32'h77; #1;
    n_vec++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_miss++; $display("FAIL flush_after got rdy=%0b v=%0b want 1/0", bus.in_ready, bus.out_valid); end
    tick();
    bus.mem_load_valid = 0;
    for (int i = 0; i < 2; i++) begin
      n_vec++; if (bus.out_valid !== 1'b0) begin n_miss++; $display("FAIL flush_no_out[%0d] got %0b want 0", i, bus.out_valid); end
      tick();
    end
    n_vec++; if (bus.stall_cnt !== 32'd4) begin n_miss++; $display("FAIL flush_stall got %0d want 4", bus.stall_cnt); end
  endtask

  task automatic test_reset_mid_wait();
    bus.rs1_choice = 0; bus.rs2_choice = 3'b011; bus.rf_rdata1 = 32'h9; bus.in_valid = 1; #1;
    tick();
    bus.in_valid = 0;
    tick();
    rst = 1; #1;
    tick();
    rst = 0; #1;
    n_vec++; if (bus.out_valid !== 1'b0 || bus.op1 !== '0 || bus.op2 !== '0 || bus.stall_cnt !== '0) begin
      n_miss++; $display("FAIL rstwait got v=%0b %h/%h cnt=%0d want 0 0/0 0", bus.out_valid, bus.op1, bus.op2, bus.stall_cnt); end
    bus.mem_load_valid = 1; bus.mem_load_data = 32'h1234; #1;
    tick();
    bus.mem_load_valid = 0;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_miss++; $display("FAIL rstwait_stray got %0b want 0", bus.out_valid); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst                = ($urandom_range(0, 599) == 0);
      bus.flush          = ($urandom_range(0, 39) == 0);
      bus.in_valid       = ($urandom_range(0, 9) < 7);
      bus.out_ready      = ($urandom_range(0, 9) < 7);
      bus.mem_load_valid = ($urandom_range(0, 9) < 3);
      bus.rs1_choice     = 3'($urandom_range(0, 7));
      bus.rs2_choice     = 3'($urandom_range(0, 7));
      bus.rf_rdata1 = $urandom; bus.rf_rdata2 = $urandom; bus.exu_result = $urandom;
      bus.wbu_wdata = $urandom; bus.mem_alu_result = $urandom; bus.mem_load_data = $urandom;
      #1;
      n_vec++; if (!rst && bus.in_ready !== model_ready()) begin
        n_miss++; $display("FAIL rand_in_ready[%0d] got %0b want %0b", i, bus.in_ready, model_ready()); end
      tick();
      n_vec++; if (bus.out_valid !== m_ov) begin
        n_miss++; $display("FAIL rand_out_valid[%0d] got %0b want %0b", i, bus.out_valid, m_ov); end
      if (m_ov) begin
        n_vec++; if (bus.op1 !== m_op1 || bus.op2 !== m_op2) begin
          n_miss++; $display("FAIL rand_ops[%0d] got %h/%h want %h/%h", i, bus.op1, bus.op2, m_op1, m_op2); end
      end
      n_vec++; if (bus.stall_cnt !== m_stall) begin
        n_miss++; $display("FAIL rand_stall[%0d] got %0d want %0d", i, bus.stall_cnt, m_stall); end
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_no_hazard();
    test_load_use();
    test_both_load_same_cycle();
    test_backpressure();
    test_flush_wait();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
